// File: rtl/complex_fu_ctrl_if.sv
// Issue / complex-ALU / writeback signal bundle for complex_fu_ctrl.
// slave = the controller; master = the issue stage, ALU and writeback environment.
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 6
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_PHYSICAL_TAG
`define SIZE_PHYSICAL_TAG 7
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 6
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 4
`endif
`ifndef SYSCALL
`define SYSCALL 6'h01
`define MULT_L  6'h10
`define MULT_H  6'h11
`define MULTU_L 6'h12
`define MULTU_H 6'h13
`define DIV_L   6'h14
`define DIV_H   6'h15
`define DIVU_L  6'h16
`define DIVU_H  6'h17
`endif

interface complex_fu_ctrl_if;
  logic                            flush_i;
  logic                            valid_i;
  logic [`SIZE_OPCODE_I-1:0]       opcode_i;
  logic [`SIZE_DATA-1:0]           data1_i;
  logic [`SIZE_DATA-1:0]           data2_i;
  logic [`SIZE_IMMEDIATE-1:0]      immd_i;
  logic [`SIZE_PHYSICAL_TAG-1:0]   tag_i;
  logic [`SIZE_ACTIVELIST_LOG-1:0] al_id_i;
  logic                            busy_o;

  logic [`SIZE_DATA-1:0]           alu_data1_o;
  logic [`SIZE_DATA-1:0]           alu_data2_o;
  logic [`SIZE_IMMEDIATE-1:0]      alu_immd_o;
  logic [`SIZE_OPCODE_I-1:0]       alu_opcode_o;
  logic [2*`SIZE_DATA-1:0]         alu_result_i;
  logic [`EXECUTION_FLAGS-1:0]     alu_flags_i;

  logic                            wb_ready_i;
  logic                            wb_valid_o;
  logic [`SIZE_PHYSICAL_TAG-1:0]   wb_tag_o;
  logic [`SIZE_ACTIVELIST_LOG-1:0] wb_al_id_o;
  logic [2*`SIZE_DATA-1:0]         wb_result_o;
  logic [`EXECUTION_FLAGS-1:0]     wb_flags_o;

  modport slave (
    input  flush_i, valid_i, opcode_i, data1_i, data2_i, immd_i, tag_i, al_id_i,
    output busy_o,
    output alu_data1_o, alu_data2_o, alu_immd_o, alu_opcode_o,
    input  alu_result_i, alu_flags_i,
    input  wb_ready_i,
    output wb_valid_o, wb_tag_o, wb_al_id_o, wb_result_o, wb_flags_o
  );

  modport master (
    output flush_i, valid_i, opcode_i, data1_i, data2_i, immd_i, tag_i, al_id_i,
    input  busy_o,
    input  alu_data1_o, alu_data2_o, alu_immd_o, alu_opcode_o,
    output alu_result_i, alu_flags_i,
    output wb_ready_i,
    input  wb_valid_o, wb_tag_o, wb_al_id_o, wb_result_o, wb_flags_o
  );
endinterface

// File: rtl/complex_fu_ctrl.sv
// Complex FU controller: holds one mul/div op in operand registers for its fixed latency, then offers a writeback packet.
// Latency: wb_valid_o L+1 cycles after acceptance (L per opcode class); backpressure: DONE holds until wb_ready_i, busy_o gates issue.
// Option COMPLEX_DIV_ZERO_EARLY_OUT_EN: divide-by-zero completes in 1 cycle with result 0 and the exception flag (bit 1) set.
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 6
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_PHYSICAL_TAG
`define SIZE_PHYSICAL_TAG 7
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 6
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 4
`endif
`ifndef SYSCALL
`define SYSCALL 6'h01
`define MULT_L  6'h10
`define MULT_H  6'h11
`define MULTU_L 6'h12
`define MULTU_H 6'h13
`define DIV_L   6'h14
`define DIV_H   6'h15
`define DIVU_L  6'h16
`define DIVU_H  6'h17
`endif

module complex_fu_ctrl #(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_LATENCY = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  complex_fu_ctrl_if.slave fu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [`EXECUTION_FLAGS-1:0] FLAG_EXC = `EXECUTION_FLAGS'(2);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] lat_m1;
  logic       load_op, capture, div_zero_in, div_zero_q;

  logic [`SIZE_OPCODE_I-1:0]       opcode_q;
  logic [`SIZE_DATA-1:0]           data1_q, data2_q;
  logic [`SIZE_IMMEDIATE-1:0]      immd_q;
  logic [`SIZE_PHYSICAL_TAG-1:0]   tag_q;
  logic [`SIZE_ACTIVELIST_LOG-1:0] al_id_q;

  logic                            wb_valid_q;
  logic [`SIZE_PHYSICAL_TAG-1:0]   wb_tag_q;
  logic [`SIZE_ACTIVELIST_LOG-1:0] wb_al_id_q;
  logic [2*`SIZE_DATA-1:0]         wb_result_q;
  logic [`EXECUTION_FLAGS-1:0]     wb_flags_q;

  function automatic logic is_mul(input logic [`SIZE_OPCODE_I-1:0] op);
    return op inside {`MULT_L, `MULT_H, `MULTU_L, `MULTU_H};
  endfunction

  function automatic logic is_div(input logic [`SIZE_OPCODE_I-1:0] op);
    return op inside {`DIV_L, `DIV_H, `DIVU_L, `DIVU_H};
  endfunction

  // Counter preload is L-1 so that the op finishes on the cycle the counter reads zero.
  always_comb begin
    div_zero_in = 1'b0;
    lat_m1      = 4'd0;
`ifdef COMPLEX_DIV_ZERO_EARLY_OUT_EN
    div_zero_in = is_div(fu.opcode_i) && (fu.data2_i == '0);
`else
    div_zero_in = 1'b0;
`endif
    if (div_zero_in) begin
      lat_m1 = 4'd0;
    end else if (is_mul(fu.opcode_i)) begin
      lat_m1 = 4'(MUL_LATENCY - 1);
    end else if (is_div(fu.opcode_i)) begin
      lat_m1 = 4'(DIV_LATENCY - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush overrides every state, including a same-cycle issue or writeback handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_op = 1'b0;
    capture = 1'b0;
    if (fu.flush_i) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fu.valid_i) begin
            load_op = 1'b1;
            cnt_d   = lat_m1;
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (fu.wb_ready_i) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q   <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      immd_q     <= '0;
      tag_q      <= '0;
      al_id_q    <= '0;
      div_zero_q <= 1'b0;
    end else if (load_op) begin
      opcode_q   <= fu.opcode_i;
      data1_q    <= fu.data1_i;
      data2_q    <= fu.data2_i;
      immd_q     <= fu.immd_i;
      tag_q      <= fu.tag_i;
      al_id_q    <= fu.al_id_i;
      div_zero_q <= div_zero_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_tag_q    <= '0;
      wb_al_id_q  <= '0;
      wb_result_q <= '0;
      wb_flags_q  <= '0;
    end else begin
      wb_valid_q <= (state_d == DONE);
      if (capture) begin
        wb_tag_q    <= tag_q;
        wb_al_id_q  <= al_id_q;
        wb_result_q <= div_zero_q ? '0 : fu.alu_result_i;
        wb_flags_q  <= fu.alu_flags_i | (div_zero_q ? FLAG_EXC : '0);
      end
    end
  end

  assign fu.busy_o       = (state_q != IDLE);
  assign fu.alu_opcode_o = opcode_q;
  assign fu.alu_data1_o  = data1_q;
  assign fu.alu_data2_o  = data2_q;
  assign fu.alu_immd_o   = immd_q;
  assign fu.wb_valid_o   = wb_valid_q;
  assign fu.wb_tag_o     = wb_tag_q;
  assign fu.wb_al_id_o   = wb_al_id_q;
  assign fu.wb_result_o  = wb_result_q;
  assign fu.wb_flags_o   = wb_flags_q;

endmodule

// File: tb/tb_complex_fu_ctrl.sv
// Randomised bench for complex_fu_ctrl: a latency/packet reference model predicts every writeback.
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 6
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_PHYSICAL_TAG
`define SIZE_PHYSICAL_TAG 7
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 6
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 4
`endif
`ifndef SYSCALL
`define SYSCALL 6'h01
`define MULT_L  6'h10
`define MULT_H  6'h11
`define MULTU_L 6'h12
`define MULTU_H 6'h13
`define DIV_L   6'h14
`define DIV_H   6'h15
`define DIVU_L  6'h16
`define DIVU_H  6'h17
`endif

module tb_complex_fu_ctrl;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  complex_fu_ctrl_if fu_if ();

  complex_fu_ctrl #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fu   (fu_if)
  );

  always #5 clk = ~clk;

  // Stand-in complex ALU: flag bit 1 is never set here, so a forced exception bit is observable.
  function automatic logic [67:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic [3:0]  f;
    r = {a, b};
    case (op)
      `MULT_L, `MULT_H:   r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      `MULTU_L, `MULTU_H: r = {32'd0, a} * {32'd0, b};
      `DIVU_L, `DIVU_H:   r = (b == 0) ? '1 : {a % b, a / b};
      `DIV_L, `DIV_H:     r = (b == 0) ? '1 : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      default:            r = {a, b};
    endcase
    f = {a[3] ^ b[3], op[2], 1'b0, a[0] ^ b[0]};
    return {f, r};
  endfunction

  function automatic bit is_div_op(input logic [5:0] op);
    return (op == `DIV_L) || (op == `DIV_H) || (op == `DIVU_L) || (op == `DIVU_H);
  endfunction

  function automatic bit early_out(input logic [5:0] op, input logic [31:0] b);
`ifdef COMPLEX_DIV_ZERO_EARLY_OUT_EN
    return is_div_op(op) && (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_lat(input logic [5:0] op, input logic [31:0] b);
    if (early_out(op, b)) return 1;
    if (is_div_op(op)) return DIV_LAT;
    if (op == `MULT_L || op == `MULT_H || op == `MULTU_L || op == `MULTU_H) return MUL_LAT;
    return 1;
  endfunction

  always_comb begin
    {fu_if.alu_flags_i, fu_if.alu_result_i} = alu_fn(fu_if.alu_opcode_o, fu_if.alu_data1_o, fu_if.alu_data2_o);
  end

  // Starts at a negedge: issues the op this cycle and follows it to the cycle after the handshake.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit poke, output logic [63:0] res_seen);
    int lat, n;
    bit ok, stable;
    logic [67:0] ref_v;
    logic [63:0] e_res;
    logic [3:0]  e_flg;
    logic [6:0]  tg;
    logic [5:0]  id;
    logic [15:0] im;
    lat   = model_lat(op, b);
    ref_v = alu_fn(op, a, b);
    e_res = early_out(op, b) ? 64'd0 : ref_v[63:0];
    e_flg = ref_v[67:64] | (early_out(op, b) ? 4'b0010 : 4'b0000);
    tg = 7'($urandom);
    id = 6'($urandom);
    im = 16'($urandom);
    fu_if.valid_i = 1'b1; fu_if.opcode_i = op; fu_if.data1_i = a; fu_if.data2_i = b;
    fu_if.immd_i = im; fu_if.tag_i = tg; fu_if.al_id_i = id;
    fu_if.wb_ready_i = (hold == 0);
    @(negedge clk);
    fu_if.valid_i = 1'b0;
    fu_if.opcode_i = 6'($urandom); fu_if.data1_i = $urandom; fu_if.data2_i = $urandom;
    fu_if.immd_i = 16'($urandom); fu_if.tag_i = ~tg; fu_if.al_id_i = ~id;
    n = 1; ok = 1'b1;
    while (fu_if.wb_valid_o !== 1'b1 && n < 40) begin
      if (fu_if.alu_data1_o !== a || fu_if.alu_data2_o !== b || fu_if.alu_opcode_o !== op ||
          fu_if.alu_immd_o !== im || fu_if.busy_o !== 1'b1) ok = 1'b0;
      fu_if.valid_i = poke && (n == 2);
      @(negedge clk);
      n++;
    end
    fu_if.valid_i = 1'b0;
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL operand_hold op=%h: ALU operands or busy_o changed during EXEC", op);
    end
    n_chk++;
    if (n != lat + 1) begin
      n_err++;
      $display("FAIL latency op=%h: wb_valid_o after %0d cycles, want %0d", op, n, lat + 1);
    end
    res_seen = fu_if.wb_result_o;
    n_chk++;
    if (fu_if.wb_result_o !== e_res || fu_if.wb_flags_o !== e_flg) begin
      n_err++;
      $display("FAIL wb_data op=%h: result=%h flags=%h, want result=%h flags=%h",
               op, fu_if.wb_result_o, fu_if.wb_flags_o, e_res, e_flg);
    end
    n_chk++;
    if (fu_if.wb_tag_o !== tg || fu_if.wb_al_id_o !== id) begin
      n_err++;
      $display("FAIL wb_meta op=%h: tag=%h al_id=%h, want tag=%h al_id=%h",
               op, fu_if.wb_tag_o, fu_if.wb_al_id_o, tg, id);
    end
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (fu_if.wb_valid_o !== 1'b1 || fu_if.wb_result_o !== e_res || fu_if.wb_flags_o !== e_flg ||
          fu_if.wb_tag_o !== tg || fu_if.wb_al_id_o !== id) stable = 1'b0;
    end
    if (hold > 0) begin
      n_chk++;
      if (!stable) begin
        n_err++;
        $display("FAIL wb_stable op=%h: packet changed while wb_ready_i=0 (hold %0d)", op, hold);
      end
    end
    fu_if.wb_ready_i = 1'b1;
    @(negedge clk);
    n_chk++;
    if (fu_if.wb_valid_o !== 1'b0 || fu_if.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL release op=%h: wb_valid_o=%b busy_o=%b, want 0 0", op, fu_if.wb_valid_o, fu_if.busy_o);
    end
    fu_if.wb_ready_i = 1'b0;
  endtask

  // Waits n cycles and reports whether wb_valid_o ever rose.
  task automatic quiet_cycles(input int n, output bit saw);
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fu_if.wb_valid_o !== 1'b0) saw = 1'b1;
    end
  endtask

  task automatic test_reset;
    n_chk++;
    if (fu_if.busy_o !== 1'b0 || fu_if.wb_valid_o !== 1'b0 || fu_if.wb_result_o !== 64'd0 ||
        fu_if.wb_tag_o !== 7'd0 || fu_if.alu_data1_o !== 32'd0 || fu_if.alu_opcode_o !== 6'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b wb_valid=%b result=%h tag=%h d1=%h opc=%h, want all zero",
               fu_if.busy_o, fu_if.wb_valid_o, fu_if.wb_result_o, fu_if.wb_tag_o,
               fu_if.alu_data1_o, fu_if.alu_opcode_o);
    end
  endtask

  task automatic test_mul_basic;
    logic [63:0] r;
    @(negedge clk);
    run_op(`MULTU_L, 32'd3, 32'd5, 0, 1'b0, r);
    n_chk++;
    if (r[31:0] !== 32'h0000_000F) begin
      n_err++;
      $display("FAIL multu_3x5: result=%h, want 0000000f", r[31:0]);
    end
  endtask

  task automatic test_div_backpressure;
    logic [63:0] r;
    @(negedge clk);
    run_op(`DIVU_L, 32'd100, 32'd7, 3, 1'b0, r);
    n_chk++;
    if (r !== {32'd2, 32'd14}) begin
      n_err++;
      $display("FAIL divu_100_7: result=%h, want 000000020000000e", r);
    end
  endtask

  task automatic test_ignore_valid;
    logic [63:0] r;
    bit saw;
    @(negedge clk);
    run_op(`DIV_H, $urandom, 32'd9, 1, 1'b1, r);
    quiet_cycles(12, saw);
    n_chk++;
    if (saw) begin
      n_err++;
      $display("FAIL ignore_valid: wb_valid_o rose for a request issued while busy, want none");
    end
  endtask

  task automatic test_flush;
    logic [63:0] r;
    bit saw;
    @(negedge clk);
    fu_if.valid_i = 1'b1; fu_if.opcode_i = `DIV_L; fu_if.data1_i = 32'd1000; fu_if.data2_i = 32'd3;
    fu_if.tag_i = 7'h55; fu_if.wb_ready_i = 1'b1;
    @(negedge clk);
    fu_if.valid_i = 1'b0;
    saw = 1'b0;
    for (int n = 1; n < 4; n++) begin
      if (fu_if.wb_valid_o !== 1'b0) saw = 1'b1;
      @(negedge clk);
    end
    fu_if.flush_i = 1'b1;
    @(negedge clk);
    fu_if.flush_i = 1'b0;
    n_chk++;
    if (fu_if.busy_o !== 1'b0 || fu_if.wb_valid_o !== 1'b0 || saw) begin
      n_err++;
      $display("FAIL flush_exec: busy=%b wb_valid=%b early_wb=%b, want 0 0 0", fu_if.busy_o, fu_if.wb_valid_o, saw);
    end
    run_op(`MULT_L, 32'hFFFF_FFFE, 32'd7, 0, 1'b0, r);
    // Flush in IDLE with a simultaneous request drops the request.
    @(negedge clk);
    fu_if.flush_i = 1'b1; fu_if.valid_i = 1'b1; fu_if.opcode_i = `MULTU_H;
    @(negedge clk);
    fu_if.flush_i = 1'b0; fu_if.valid_i = 1'b0;
    quiet_cycles(8, saw);
    n_chk++;
    if (fu_if.busy_o !== 1'b0 || saw) begin
      n_err++;
      $display("FAIL flush_drops_valid: busy=%b wb_seen=%b, want 0 0", fu_if.busy_o, saw);
    end
  endtask

  task automatic test_flush_vs_handshake;
    int n;
    @(negedge clk);
    fu_if.valid_i = 1'b1; fu_if.opcode_i = `MULTU_H; fu_if.data1_i = $urandom; fu_if.data2_i = $urandom;
    fu_if.wb_ready_i = 1'b0;
    @(negedge clk);
    fu_if.valid_i = 1'b0;
    n = 0;
    while (fu_if.wb_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    fu_if.wb_ready_i = 1'b1; fu_if.flush_i = 1'b1;
    @(negedge clk);
    fu_if.wb_ready_i = 1'b0; fu_if.flush_i = 1'b0;
    n_chk++;
    if (n >= 40 || fu_if.wb_valid_o !== 1'b0 || fu_if.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_in_done: waited=%0d wb_valid=%b busy=%b, want <40 0 0", n, fu_if.wb_valid_o, fu_if.busy_o);
    end
  endtask

  task automatic test_reset_mid_op(input bit in_done);
    int n;
    bit saw;
    @(negedge clk);
    fu_if.valid_i = 1'b1; fu_if.opcode_i = `DIVU_H; fu_if.data1_i = 32'd77; fu_if.data2_i = 32'd5;
    fu_if.wb_ready_i = 1'b0;
    @(negedge clk);
    fu_if.valid_i = 1'b0;
    n = 0;
    while ((in_done ? fu_if.wb_valid_o !== 1'b1 : n < 3) && n < 40) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (n >= 40 || fu_if.wb_valid_o !== 1'b0 || fu_if.busy_o !== 1'b0 ||
        fu_if.wb_result_o !== 64'd0 || fu_if.alu_data1_o !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset(done=%0d): waited=%0d wb_valid=%b busy=%b result=%h d1=%h, want all zero",
               in_done, n, fu_if.wb_valid_o, fu_if.busy_o, fu_if.wb_result_o, fu_if.alu_data1_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fu_if.wb_ready_i = 1'b1;
    quiet_cycles(15, saw);
    fu_if.wb_ready_i = 1'b0;
    n_chk++;
    if (saw || fu_if.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard(done=%0d): wb_seen=%b busy=%b, want 0 0", in_done, saw, fu_if.busy_o);
    end
  endtask

  task automatic test_div_zero;
    logic [63:0] r;
    @(negedge clk);
    run_op(`DIVU_L, 32'd5, 32'd0, 0, 1'b0, r);
    n_chk++;
`ifdef COMPLEX_DIV_ZERO_EARLY_OUT_EN
    if (r !== 64'd0) begin
      n_err++;
      $display("FAIL div_zero_result: result=%h, want 0", r);
    end
`else
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL div_zero_result: result=%h, want ALU value ffffffffffffffff", r);
    end
`endif
  endtask

  task automatic test_random;
    logic [5:0]  ops [10];
    logic [63:0] r;
    logic [31:0] b;
    ops = '{`MULT_L, `MULT_H, `MULTU_L, `MULTU_H, `DIV_L, `DIV_H, `DIVU_L, `DIVU_H, `SYSCALL, 6'h3F};
    for (int i = 0; i < 14; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      @(negedge clk);
      run_op(ops[$urandom_range(0, 9)], $urandom, b, $urandom_range(0, 3), 1'b0, r);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r;
    run_op(`SYSCALL, $urandom, $urandom, 0, 1'b0, r);
    run_op(`MULT_H, $urandom, $urandom, 0, 1'b0, r);
    run_op(`DIV_L, $urandom, 32'd13, 2, 1'b0, r);
  endtask

  initial begin
    fu_if.flush_i = 1'b0; fu_if.valid_i = 1'b0; fu_if.opcode_i = '0;
    fu_if.data1_i = '0; fu_if.data2_i = '0; fu_if.immd_i = '0;
    fu_if.tag_i = '0; fu_if.al_id_i = '0; fu_if.wb_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_mul_basic;
    test_div_backpressure;
    test_ignore_valid;
    test_flush;
    test_flush_vs_handshake;
    test_reset_mid_op(1'b0);
    test_reset_mid_op(1'b1);
    test_div_zero;
    test_random;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
